// File: rtl/data_ext_pipe.sv
// data_ext_pipe -- load-data extension stage with a two-entry output buffer.
//
// Selects a byte or halfword lane from a raw memory word using the byte
// offset, then zero- or sign-extends it to DATA_W. Words can also pass
// through unchanged. The extended result is registered, so an empty pipe
// produces it one cycle after the input is accepted. A skid register absorbs
// one extra beat, which lets in_ready come straight from a flop.
//
// Optional feature: define DATA_EXT_ALIGN_CHK_EN to add the out_misalign port.
// The flag travels through the pipe alongside its data.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   flush            synchronous discard of all held entries (dominates)
//   in_valid/ready   input handshake; in_ready is registered
//   in_data          raw memory word
//   in_off           byte offset within the word
//   in_op            000 word, 001 byte zext, 010 byte sext, 011 half zext,
//                    100 half sext, 101-111 word
//   out_valid/ready  output handshake
//   out_data         extended result
//   out_misalign     alignment fault flag (only with DATA_EXT_ALIGN_CHK_EN)
module data_ext_pipe #(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [2:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef DATA_EXT_ALIGN_CHK_EN
  output logic              out_misalign,
`endif
  output logic [DATA_W-1:0] out_data
);

  // Each entry holds the data, plus the misalign flag when checking is on.
`ifdef DATA_EXT_ALIGN_CHK_EN
  localparam int PAY_W = DATA_W + 1;
`else
  localparam int PAY_W = DATA_W;
`endif

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [PAY_W-1:0]  out_q, out_d;
  logic [PAY_W-1:0]  skid_q, skid_d;

  logic [DATA_W-1:0] sh_b, sh_h, ext_data;
  logic [PAY_W-1:0]  in_pay;
  logic              in_fire, out_fire;

  // Shifting the chosen lane down to bit 0 selects it. The half lane ignores
  // in_off[0], so it always starts at an even byte.
  assign sh_b = in_data >> {in_off, 3'b000};
  assign sh_h = in_data >> {in_off[OFF_W-1:1], 4'b0000};

  always_comb begin
    ext_data = in_data;
    case (in_op)
      3'b001:  ext_data = {{(DATA_W-8){1'b0}},       sh_b[7:0]};
      3'b010:  ext_data = {{(DATA_W-8){sh_b[7]}},    sh_b[7:0]};
      3'b011:  ext_data = {{(DATA_W-16){1'b0}},      sh_h[15:0]};
      3'b100:  ext_data = {{(DATA_W-16){sh_h[15]}},  sh_h[15:0]};
      default: ext_data = in_data;
    endcase
  end

`ifdef DATA_EXT_ALIGN_CHK_EN
  logic mis_in;
  always_comb begin
    mis_in = 1'b0;
    case (in_op)
      3'b001, 3'b010: mis_in = 1'b0;
      3'b011, 3'b100: mis_in = in_off[0];
      default:        mis_in = (in_off != '0);
    endcase
  end
  assign in_pay = {mis_in, ext_data};
`else
  assign in_pay = ext_data;
`endif

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          out_d   = in_pay;
          state_d = ONE;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            out_d = in_pay;
          end else if (in_fire) begin
            skid_d  = in_pay;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        // in_ready is low here, so no input can arrive; just drain the skid.
        FULL: if (out_fire) begin
          out_d   = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == ONE) || (state_q == FULL);
  assign out_data  = out_q[DATA_W-1:0];
`ifdef DATA_EXT_ALIGN_CHK_EN
  assign out_misalign = out_q[DATA_W];
`endif

endmodule

// File: doc/data_ext_pipe.md
DATA_EXT_PIPE -- requirements
Module: data_ext_pipe

Interface
REQ-001 SHALL expose parameter: DATA_W, 32, data width in bits; legal values 32 and 64.
REQ-002 SHALL expose parameter: OFF_W, log2(DATA_W/8), byte-offset width; derived, not overridden.
REQ-003 SHALL have ports: clk  in  1  clock, rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: flush  in  1  synchronous discard of all held entries.
REQ-006 SHALL have ports: in_valid  in  1  input beat valid.
REQ-007 SHALL have ports: in_ready  out  1  module accepts input beat.
REQ-008 SHALL have ports: in_data  in  DATA_W  raw memory word.
REQ-009 SHALL have ports: in_off  in  OFF_W  byte address offset.
REQ-010 SHALL have ports: in_op  in  3  extend mode.
REQ-011 SHALL have ports: out_valid  out  1  output beat valid.
REQ-012 SHALL have ports: out_ready  in  1  consumer accepts output beat.
REQ-013 SHALL have ports: out_data  out  DATA_W  extended result.
REQ-014 SHALL have ports: out_misalign  out  1  alignment fault flag (present only with DATA_EXT_ALIGN_CHK_EN).

Function
REQ-015 SHALL decode in_op: 000 word pass, 001 byte zero-ext, 010 byte sign-ext, 011 half zero-ext, 100 half sign-ext, 101-111 word pass.
REQ-016 SHALL select byte lane in_data[8*in_off +: 8] and half lane in_data[8*{in_off[OFF_W-1:1],1'b0} +: 16]; extension fills bits up to DATA_W.
REQ-017 SHALL compute extension combinationally at input and register the result; input-to-output latency is exactly 1 cycle when empty.
REQ-018 SHALL hold up to 2 entries (output register + skid register); states EMPTY, ONE, FULL.
REQ-019 SHALL drive in_ready from a register: 1 in EMPTY and ONE, 0 in FULL.
REQ-020 SHALL transfer input when in_valid and in_ready; output when out_valid and out_ready.
REQ-021 SHALL transition: EMPTY->ONE on input; ONE->EMPTY on output without input; ONE stays ONE on simultaneous input and output; ONE->FULL on input without output; FULL->ONE on output (no input accepted in FULL).
REQ-022 SHALL keep out_data, out_misalign stable while out_valid=1 and out_ready=0.
REQ-023 SHALL preserve order: skid entry moves to output register when output register drains.
REQ-024 SHALL, on flush=1, go to EMPTY at next edge, discard any same-cycle input, and drop out_valid; flush dominates all other events.
REQ-025 SHALL drive out_valid=1 exactly in ONE and FULL.

Reset
REQ-026 SHALL on reset asynchronously force EMPTY, in_ready=1 (first cycle after release), out_valid=0, out_data=0, out_misalign=0, skid register=0.
REQ-027 SHALL discard in-flight entries on reset mid-operation; no beat emitted after release until a new input is accepted.

Configuration
REQ-028 SHALL use macro DATA_EXT_ALIGN_CHK_EN.
REQ-029 SHALL, when defined, set out_misalign=1 for half ops with in_off[0]=1 and word-pass ops with in_off!=0, carried through the pipe with its data; data still computed per REQ-016.
REQ-030 SHALL, when undefined, omit out_misalign port and checking logic; all other behaviour identical.

Verification
REQ-031 SHALL cover: DATA_W=32, in_data=0x80F17F00, op=010, off=2 -> out_data=0xFFFFFFF1 one cycle later.
REQ-032 SHALL cover: same data, op=011, off=2 -> 0x000080F1; op=100, off=2 -> 0xFFFF80F1; op=001, off=1 -> 0x0000007F.
REQ-033 SHALL cover: out_ready=0 for 3 cycles with 3 inputs offered -> 2 accepted, in_ready=0 after 2nd, outputs later emerge in order, third accepted after first drain.
REQ-034 SHALL cover: flush asserted in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted.
REQ-035 SHALL cover: with DATA_EXT_ALIGN_CHK_EN, op=100, off=1 -> out_misalign=1; op=000, off=0 -> out_misalign=0.
REQ-036 SHALL cover: reset asserted mid-cycle in ONE -> out_valid falls immediately, out_data=0, no stale beat after release.
